// File: rtl/draw_pkg.sv
// Shared widths, colours and draw-FSM state encoding for the shape engines.
package draw_pkg;

  localparam int unsigned COORD_W  = 11;
  localparam int unsigned COLOUR_W = 3;

  localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
  localparam logic [COLOUR_W-1:0] WHITE = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StErase,
    StDraw,
    StDone
  } draw_state_e;

endpackage

// File: rtl/rect_scanner.sv
// Row-major cx/cy pixel counter for one rectangle pass; exposes next-cycle values so
// the owner can register pixel outputs in the same edge the counter moves.
module rect_scanner #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned HEIGHT = 8
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       clear,
  input  logic       advance,
  output logic [5:0] cx_next,
  output logic [5:0] cy_next,
  output logic       last
);

  localparam logic [5:0] LastCx = 6'(WIDTH - 1);
  localparam logic [5:0] LastCy = 6'(HEIGHT - 1);

  logic [5:0] cx_q, cy_q;

  assign last = (cx_q == LastCx) && (cy_q == LastCy);

  always_comb begin
    cx_next = cx_q;
    cy_next = cy_q;
    if (clear) begin
      cx_next = '0;
      cy_next = '0;
    end else if (advance) begin
      if (cx_q == LastCx) begin
        cx_next = '0;
        cy_next = cy_q + 6'd1;
      end else begin
        cx_next = cx_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_next;
      cy_q <= cy_next;
    end
  end

endmodule

// File: rtl/shape_draw_engine.sv
// One on-screen rectangle: scrolls left on frame ticks and, on request, streams an
// optional erase pass over its last drawn spot followed by a draw pass.
module shape_draw_engine
  import draw_pkg::*;
#(
  parameter logic [COORD_W-1:0]  START_X   = 11'd152,
  parameter logic [COORD_W-1:0]  START_Y   = 11'd100,
  parameter int unsigned         WIDTH     = 8,
  parameter int unsigned         HEIGHT    = 8,
  parameter logic [COLOUR_W-1:0] COLOUR    = WHITE,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = BLACK,
  parameter int unsigned         SPEED     = 1,
  parameter int unsigned         SCREEN_W  = 160
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                reset,
  input  logic                draw_start,
  input  logic                update_screen,
  output logic                draw_done,
  output logic [COORD_W-1:0]  x,
  output logic [COORD_W-1:0]  y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic [COORD_W-1:0]  shape_gone
);

  localparam logic [COORD_W-1:0] Speed   = COORD_W'(SPEED);
  localparam logic [COORD_W-1:0] ScreenW = COORD_W'(SCREEN_W);

  draw_state_e state_q, state_d;
  logic [COORD_W-1:0] pos_x_q, pos_x_d;
  logic [COORD_W-1:0] last_x_q, last_x_d;
  logic [COORD_W-1:0] base_x_q, base_x_d;
  logic gone_q, gone_d;
  logic drawn_once_q, drawn_once_d;
  logic erase_pending_q, erase_pending_d;

  logic [COORD_W-1:0]  x_d, y_d;
  logic [COLOUR_W-1:0] colour_d;
  logic                plot_d, done_d;

  logic       scan_clear, scan_advance, scan_last;
  logic [5:0] cx_next, cy_next;

  rect_scanner #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT)
  ) u_scanner (
    .clock  (clock),
    .resetn (resetn),
    .clear  (scan_clear),
    .advance(scan_advance),
    .cx_next(cx_next),
    .cy_next(cy_next),
    .last   (scan_last)
  );

  // Next state, pass setup and movement.
  always_comb begin
    state_d         = state_q;
    pos_x_d         = pos_x_q;
    last_x_d        = last_x_q;
    base_x_d        = base_x_q;
    gone_d          = gone_q;
    drawn_once_d    = drawn_once_q;
    erase_pending_d = erase_pending_q;
    scan_clear      = 1'b0;
    scan_advance    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (draw_start) begin
          if (erase_pending_q) begin
            state_d    = StErase;
            base_x_d   = last_x_q;
            scan_clear = 1'b1;
          end else if (gone_q) begin
            state_d = StDone;
          end else begin
            state_d      = StDraw;
            base_x_d     = pos_x_q;
            last_x_d     = pos_x_q;
            drawn_once_d = 1'b1;
            scan_clear   = 1'b1;
          end
        end
      end
      StErase: begin
        if (!draw_start) begin
          state_d = StIdle;
        end else if (scan_last) begin
          erase_pending_d = 1'b0;
          if (gone_q) begin
            state_d = StDone;
          end else begin
            state_d      = StDraw;
            base_x_d     = pos_x_q;
            last_x_d     = pos_x_q;
            drawn_once_d = 1'b1;
            scan_clear   = 1'b1;
          end
        end else begin
          scan_advance = 1'b1;
        end
      end
      StDraw: begin
        if (!draw_start) begin
          state_d = StIdle;
        end else if (scan_last) begin
          state_d = StDone;
        end else begin
          scan_advance = 1'b1;
        end
      end
      StDone: begin
        if (!draw_start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A move after any draw leaves a stale image; it wins over an erase finishing now.
    if (update_screen && !gone_q) begin
      if (pos_x_q < Speed) gone_d = 1'b1;
      else                 pos_x_d = pos_x_q - Speed;
      if (drawn_once_d) erase_pending_d = 1'b1;
    end

    if (reset) begin
      state_d         = StIdle;
      pos_x_d         = START_X;
      last_x_d        = START_X;
      base_x_d        = START_X;
      gone_d          = 1'b0;
      drawn_once_d    = 1'b0;
      erase_pending_d = 1'b0;
      scan_clear      = 1'b1;
      scan_advance    = 1'b0;
    end
  end

  // Registered pixel outputs follow the state and counter values being loaded.
  always_comb begin
    x_d      = '0;
    y_d      = '0;
    colour_d = '0;
    plot_d   = 1'b0;
    done_d   = (state_d == StDone);
    if (state_d == StErase || state_d == StDraw) begin
      x_d      = base_x_d + {5'd0, cx_next};
      y_d      = START_Y + {5'd0, cy_next};
      colour_d = (state_d == StErase) ? BG_COLOUR : COLOUR;
      plot_d   = (x_d < ScreenW);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q         <= StIdle;
      pos_x_q         <= START_X;
      last_x_q        <= START_X;
      base_x_q        <= START_X;
      gone_q          <= 1'b0;
      drawn_once_q    <= 1'b0;
      erase_pending_q <= 1'b0;
      x               <= '0;
      y               <= '0;
      colour          <= '0;
      plot            <= 1'b0;
      draw_done       <= 1'b0;
    end else begin
      state_q         <= state_d;
      pos_x_q         <= pos_x_d;
      last_x_q        <= last_x_d;
      base_x_q        <= base_x_d;
      gone_q          <= gone_d;
      drawn_once_q    <= drawn_once_d;
      erase_pending_q <= erase_pending_d;
      x               <= x_d;
      y               <= y_d;
      colour          <= colour_d;
      plot            <= plot_d;
      draw_done       <= done_d;
    end
  end

  assign shape_gone = {10'd0, gone_q};

endmodule

// File: tb/tb_shape_draw_engine.sv
// Directed bench for shape_draw_engine: three instances cover move/erase/abort/soft
// reset, scrolling off the left edge, and right-edge clipping.
module tb_shape_draw_engine;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic resetn;

  logic        a_reset, a_ds, a_upd, a_done, a_plot;
  logic [10:0] a_x, a_y, a_gone;
  logic [2:0]  a_colour;
  logic        g_reset, g_ds, g_upd, g_done, g_plot;
  logic [10:0] g_x, g_y, g_gone;
  logic [2:0]  g_colour;
  logic        c_reset, c_ds, c_upd, c_done, c_plot;
  logic [10:0] c_x, c_y, c_gone;
  logic [2:0]  c_colour;

  int errors = 0;
  int checks = 0;

  shape_draw_engine #(
    .START_X(11'd10), .START_Y(11'd20), .WIDTH(2), .HEIGHT(2),
    .COLOUR(3'b111), .BG_COLOUR(3'b000), .SPEED(1), .SCREEN_W(160)
  ) u_a (
    .clock(clock), .resetn(resetn), .reset(a_reset), .draw_start(a_ds),
    .update_screen(a_upd), .draw_done(a_done), .x(a_x), .y(a_y),
    .colour(a_colour), .plot(a_plot), .shape_gone(a_gone)
  );

  shape_draw_engine #(
    .START_X(11'd1), .START_Y(11'd5), .WIDTH(2), .HEIGHT(2),
    .COLOUR(3'b111), .BG_COLOUR(3'b000), .SPEED(1), .SCREEN_W(160)
  ) u_g (
    .clock(clock), .resetn(resetn), .reset(g_reset), .draw_start(g_ds),
    .update_screen(g_upd), .draw_done(g_done), .x(g_x), .y(g_y),
    .colour(g_colour), .plot(g_plot), .shape_gone(g_gone)
  );

  shape_draw_engine #(
    .START_X(11'd158), .START_Y(11'd0), .WIDTH(4), .HEIGHT(2),
    .COLOUR(3'b111), .BG_COLOUR(3'b000), .SPEED(1), .SCREEN_W(160)
  ) u_c (
    .clock(clock), .resetn(resetn), .reset(c_reset), .draw_start(c_ds),
    .update_screen(c_upd), .draw_done(c_done), .x(c_x), .y(c_y),
    .colour(c_colour), .plot(c_plot), .shape_gone(c_gone)
  );

  wire [25:0] pa = {a_plot, a_colour, a_x, a_y};
  wire [25:0] pg = {g_plot, g_colour, g_x, g_y};
  wire [25:0] pc = {c_plot, c_colour, c_x, c_y};

  function automatic logic [25:0] px(input logic p, input logic [2:0] c, input int xx,
                                     input int yy);
    return {p, c, 11'(xx), 11'(yy)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Four pixels of a 2x2 pass, one per cycle, starting the cycle after the request.
  task automatic sq(input int sel, input string tag, input logic [2:0] c, input int bx,
                    input int by);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk(tag, {6'd0, (sel == 0) ? pa : pg}, {6'd0, px(1'b1, c, bx + i % 2, by + i / 2)});
    end
  endtask

  initial begin
    resetn  = 1'b0;
    a_reset = 0; a_ds = 0; a_upd = 0;
    g_reset = 0; g_ds = 0; g_upd = 0;
    c_reset = 0; c_ds = 0; c_upd = 0;
    tick(); tick();
    chk("rst_a_done", {31'd0, a_done}, 32'd0);
    chk("rst_a_pix", {6'd0, pa}, 32'd0);
    chk("rst_a_gone", {21'd0, a_gone}, 32'd0);
    chk("rst_g_pix", {6'd0, pg}, 32'd0);
    resetn = 1'b1;
    tick();

    // First draw at (10,20)
    a_ds = 1;
    sq(0, "a_draw1", 3'd7, 10, 20);
    tick();
    chk("a_done1", {30'd0, a_done, a_plot}, 32'b10);
    a_ds = 0;
    tick();
    chk("a_done1_drop", {31'd0, a_done}, 32'd0);

    // Move left by one, then erase old spot and draw new one
    a_upd = 1; tick(); a_upd = 0; tick();
    a_ds = 1;
    sq(0, "a_erase2", 3'd0, 10, 20);
    sq(0, "a_draw2", 3'd7, 9, 20);
    tick();
    chk("a_done2", {30'd0, a_done, a_plot}, 32'b10);
    a_ds = 0;
    tick();

    // Abort with a move during the draw pass
    a_ds = 1;
    tick();
    chk("a_abort_p0", {6'd0, pa}, {6'd0, px(1'b1, 3'd7, 9, 20)});
    a_upd = 1;
    tick();
    chk("a_abort_p1", {6'd0, pa}, {6'd0, px(1'b1, 3'd7, 10, 20)});
    a_upd = 0; a_ds = 0;
    tick();
    chk("a_abort_idle", {30'd0, a_done, a_plot}, 32'd0);
    tick(); tick();
    chk("a_abort_nodone", {31'd0, a_done}, 32'd0);
    a_ds = 1;
    sq(0, "a_erase3", 3'd0, 9, 20);
    sq(0, "a_draw3", 3'd7, 8, 20);
    tick();
    chk("a_done3", {31'd0, a_done}, 32'd1);
    a_ds = 0;
    tick();

    // Soft reset during the second draw pixel
    a_ds = 1;
    tick();
    chk("a_sr_p0", {6'd0, pa}, {6'd0, px(1'b1, 3'd7, 8, 20)});
    tick();
    chk("a_sr_p1", {6'd0, pa}, {6'd0, px(1'b1, 3'd7, 9, 20)});
    a_reset = 1;
    tick();
    chk("a_sr_pix", {6'd0, pa}, 32'd0);
    chk("a_sr_done", {31'd0, a_done}, 32'd0);
    chk("a_sr_gone", {21'd0, a_gone}, 32'd0);
    a_reset = 0; a_ds = 0;
    tick();
    a_ds = 1;
    sq(0, "a_sr_draw", 3'd7, 10, 20);
    tick();
    chk("a_sr_done2", {31'd0, a_done}, 32'd1);
    a_ds = 0;
    tick();

    // Scroll off the left edge
    g_ds = 1;
    sq(1, "g_draw", 3'd7, 1, 5);
    tick();
    chk("g_done1", {31'd0, g_done}, 32'd1);
    g_ds = 0;
    tick();
    g_upd = 1; tick(); g_upd = 0;
    chk("g_gone_at0", {21'd0, g_gone}, 32'd0);
    tick();
    g_upd = 1; tick(); g_upd = 0;
    chk("g_gone_set", {21'd0, g_gone}, 32'd1);
    g_ds = 1;
    sq(1, "g_erase", 3'd0, 1, 5);
    tick();
    chk("g_done_erase", {30'd0, g_done, g_plot}, 32'b10);
    g_ds = 0;
    tick();
    chk("g_done_drop", {31'd0, g_done}, 32'd0);
    g_ds = 1;
    tick();
    chk("g_done_direct", {30'd0, g_done, g_plot}, 32'b10);
    g_ds = 0; g_upd = 1;
    tick();
    g_upd = 0;
    tick();
    chk("g_gone_sticky", {21'd0, g_gone}, 32'd1);

    // Right-edge clipping
    c_ds = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("c_clip", {6'd0, pc},
          {6'd0, px((158 + i % 4) < 160, 3'd7, 158 + i % 4, i / 4)});
    end
    tick();
    chk("c_done", {30'd0, c_done, c_plot}, 32'b10);
    c_ds = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shape_draw_engine.md
Name: shape_draw_engine

Overview:
- Per-shape responder on the draw handshake driven by the game sequencer; one instance per on-screen object (blocks, square frames, black screen).
- Holds the shape's position and scrolls it left on each frame tick.
- On draw_start it streams the shape's pixels (x, y, colour) one per clock: an optional erase pass over the last drawn rectangle, then a draw pass at the current position. It then raises draw_done and holds it until draw_start is released.
- Reports shape_gone once the shape has scrolled off the left edge; the sequencer sums these flags into the score.

Parameters:
- START_X, 11'd152, left-edge x after reset
- START_Y, 11'd100, top-edge y after reset
- WIDTH, 8, rectangle width in pixels (1..64)
- HEIGHT, 8, rectangle height in pixels (1..64)
- COLOUR, 3'b111, draw-pass colour
- BG_COLOUR, 3'b000, erase-pass colour
- SPEED, 1, pixels moved left per update_screen pulse (1..15)
- SCREEN_W, 160, visible width; pixels at x >= SCREEN_W are clipped

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- reset  in  1  synchronous active-high soft reset from the sequencer (game restart)
- draw_start  in  1  request level from the sequencer; held until draw_done is seen
- update_screen  in  1  one-cycle frame tick
- draw_done  out  1  pass complete; held while draw_start stays high
- x  out  11  pixel x
- y  out  11  pixel y
- colour  out  3  pixel colour
- plot  out  1  pixel valid (x, y, colour meaningful)
- shape_gone  out  11  0 or 1, zero-extended; sticky

Behaviour:
- Asynchronous resetn low, or synchronous reset high (reset overrides all other inputs):
  - outputs: draw_done=0, plot=0, x=0, y=0, colour=0, shape_gone=0
  - internal: state=IDLE, pos_x=START_X, pos_y=START_Y, drawn_once=0, erase_pending=0
- Movement, on update_screen=1, applied in any state, while not gone:
  - if pos_x < SPEED: set gone=1 and leave pos_x unchanged
  - else: pos_x -= SPEED
  - in either case, if drawn_once: set erase_pending=1
  - if already gone: update_screen is ignored
- Pass base coordinates are latched at pass entry, so a move during a pass does not affect that pass.
- FSM states: IDLE, ERASE, DRAW, DONE.
- IDLE, on draw_start=1:
  - if erase_pending: go to ERASE with base = last_x, pos_y
  - else if gone: go to DONE
  - else: go to DRAW with base = pos_x, pos_y; set last_x=pos_x and drawn_once=1
- ERASE and DRAW scan:
  - 6-bit cx, cy; row-major order (cx fastest); one pixel per clock
  - outputs are registered: x=base_x+cx, y=base_y+cy
  - colour = BG_COLOUR in ERASE, COLOUR in DRAW
  - plot=1 except when x >= SCREEN_W (clipped pixels still take their cycle)
- Exit from ERASE on the last pixel (cx=WIDTH-1, cy=HEIGHT-1): clear erase_pending, then go to DONE if gone, else to DRAW (latching base and last_x as above).
- Exit from DRAW on the last pixel: go to DONE.
- Latency:
  - first pixel is on the outputs in the cycle after draw_start is sampled in IDLE
  - draw_done rises in the cycle after the last pixel
  - total pixel cycles: WIDTH*HEIGHT per pass, doubled when an erase pass runs
- DONE: draw_done=1 and plot=0. When draw_start=0, go to IDLE and drop draw_done in the same edge. draw_done never rises while draw_start=0.
- Abort: if draw_start drops during ERASE or DRAW, return to IDLE with plot=0.
  - erase_pending is unchanged if the abort happens in ERASE.
  - the DRAW pass is considered done for last_x purposes.
- shape_gone = {10'd0, gone}; it is cleared only by resetn or reset.
- Arithmetic:
  - pixel coordinates are computed as 11-bit unsigned with no wrap checking beyond clipping
  - pos_y is constant

Decomposition:
- Shared package draw_pkg:
  - COORD_W=11, COLOUR_W=3
  - BLACK=3'b000, WHITE=3'b111
  - state encoding enum (IDLE, ERASE, DRAW, DONE)
- Sub-module rect_scanner: cx/cy counters with start/clear and a last-pixel flag, reused by both passes.
- The FSM and position logic stay in the top module.

Test Plan:
- Reset and first draw:
  - stimulus: resetn pulse, WIDTH=HEIGHT=2, START_X=10, START_Y=20, draw_start=1
  - response: plot for 4 cycles at (10,20),(11,20),(10,21),(11,21), colour 7; draw_done=1 the next cycle; drop draw_start -> draw_done=0 one cycle later
- Move with erase:
  - stimulus: after the first draw, one update_screen pulse, then draw_start
  - response: 4 erase pixels at x=10..11 with colour 0, then 4 draw pixels at x=9..10 with colour 7; draw_done after 8 pixel cycles
- Gone:
  - stimulus: START_X=1, SPEED=1, draw, then 2 update_screen pulses
  - response: pos_x=0 after the first pulse; second pulse sets shape_gone=11'd1; next draw_start gives an erase pass only, then DONE; further pulses leave shape_gone=1
- Clipping:
  - stimulus: START_X=158, WIDTH=4, SCREEN_W=160
  - response: 4 cycles per row; plot=1 only at x=158 and 159
- Soft reset mid-pass:
  - stimulus: assert reset during the DRAW pixel cycle 2
  - response: next cycle state=IDLE, plot=0, draw_done=0, pos_x=START_X, shape_gone=0
- Abort and update during a pass:
  - stimulus: update_screen during DRAW, then draw_start dropped before the last pixel
  - response: IDLE with no draw_done; next request erases at the old last_x, then draws at the moved position
